// File: rtl/mmio_bridge.sv
// M-stage system bridge: address decode, store steering, read mux, HW interrupts.
// Optional BRIDGE_HWINT_SYNC_EN adds 2-flop synchronizers on the interrupt inputs.
module mmio_bridge #(
  parameter logic [31:0] DM_HI  = 32'h0000_2FFF,
  parameter logic [31:0] IM_LO  = 32'h0000_3000,
  parameter logic [31:0] IM_HI  = 32'h0000_6FFF,
  parameter logic [31:0] TC0_LO = 32'h0000_7F00,
  parameter logic [31:0] TC1_LO = 32'h0000_7F10,
  parameter logic [31:0] IG_LO  = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr_Bridge,
  input  logic [31:0] IM_Read,
  input  logic [31:0] DM_Read,
  input  logic [31:0] TC0_Read,
  input  logic [31:0] TC1_Read,
  input  logic [3:0]  cpu_m_data_byteen,
  input  logic        IRQ0,
  input  logic        IRQ1,
  input  logic        Interrupt,
  output logic        TC0_RegWrite,
  output logic        TC1_RegWrite,
  output logic [3:0]  bridge_m_data_byteen,
  output logic [5:0]  HWInt,
  output logic [31:0] Bridge_Read
);

  localparam logic [31:0] TC0_HI = TC0_LO + 32'd11;
  localparam logic [31:0] TC1_HI = TC1_LO + 32'd11;
  localparam logic [31:0] IG_HI  = IG_LO + 32'd3;

  typedef enum logic [2:0] {
    R_NONE, R_DM, R_IM, R_TC0, R_TC1, R_IG
  } region_e;

  region_e region_d;
  region_e rq_q;
  logic    store;

  always_comb begin
    region_d = R_NONE;
    unique case (1'b1)
      (Addr_Bridge <= DM_HI):
        region_d = R_DM;
      (Addr_Bridge >= IM_LO && Addr_Bridge <= IM_HI):
        region_d = R_IM;
      (Addr_Bridge >= TC0_LO && Addr_Bridge <= TC0_HI):
        region_d = R_TC0;
      (Addr_Bridge >= TC1_LO && Addr_Bridge <= TC1_HI):
        region_d = R_TC1;
      (Addr_Bridge >= IG_LO && Addr_Bridge <= IG_HI):
        region_d = R_IG;
      default: region_d = R_NONE;
    endcase
  end

  assign store        = |cpu_m_data_byteen;
  assign TC0_RegWrite = store && (region_d == R_TC0);
  assign TC1_RegWrite = store && (region_d == R_TC1);

  // Stores to IM or unmapped space are dropped here.
  assign bridge_m_data_byteen =
    (region_d == R_DM || region_d == R_IG) ? cpu_m_data_byteen : 4'b0000;

  always_ff @(posedge clk) begin
    if (!reset) rq_q <= R_NONE;
    else        rq_q <= region_d;
  end

  always_comb begin
    Bridge_Read = 32'h0;
    unique case (rq_q)
      R_DM:    Bridge_Read = DM_Read;
      R_IM:    Bridge_Read = IM_Read;
      R_TC0:   Bridge_Read = TC0_Read;
      R_TC1:   Bridge_Read = TC1_Read;
      default: Bridge_Read = 32'h0;
    endcase
  end

`ifdef BRIDGE_HWINT_SYNC_EN
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {Interrupt, IRQ1, IRQ0};
      sync2_q <= sync1_q;
    end
  end

  assign HWInt = {3'b000, sync2_q};
`else
  assign HWInt = {3'b000, Interrupt, IRQ1, IRQ0};
`endif

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: directed plan vectors then random traffic.
// Expected outputs are queued per cycle and checked by a separate monitor.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr_Bridge;
  logic [31:0] IM_Read, DM_Read, TC0_Read, TC1_Read;
  logic [3:0]  cpu_m_data_byteen;
  logic        IRQ0, IRQ1, Interrupt;
  logic        TC0_RegWrite, TC1_RegWrite;
  logic [3:0]  bridge_m_data_byteen;
  logic [5:0]  HWInt;
  logic [31:0] Bridge_Read;

  always #5 clk = ~clk;

  mmio_bridge dut (
    .clk(clk),
    .reset(reset),
    .Addr_Bridge(Addr_Bridge),
    .IM_Read(IM_Read),
    .DM_Read(DM_Read),
    .TC0_Read(TC0_Read),
    .TC1_Read(TC1_Read),
    .cpu_m_data_byteen(cpu_m_data_byteen),
    .IRQ0(IRQ0),
    .IRQ1(IRQ1),
    .Interrupt(Interrupt),
    .TC0_RegWrite(TC0_RegWrite),
    .TC1_RegWrite(TC1_RegWrite),
    .bridge_m_data_byteen(bridge_m_data_byteen),
    .HWInt(HWInt),
    .Bridge_Read(Bridge_Read)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model: address map as plain region numbers.
  // 0 none, 1 DM, 2 IM, 3 TC0, 4 TC1, 5 IG
  function automatic int region_of(input logic [31:0] a);
    if (a <= 32'h2FFF) return 1;
    if (a >= 32'h3000 && a <= 32'h6FFF) return 2;
    if (a >= 32'h7F00 && a <= 32'h7F0B) return 3;
    if (a >= 32'h7F10 && a <= 32'h7F1B) return 4;
    if (a >= 32'h7F20 && a <= 32'h7F23) return 5;
    return 0;
  endfunction

  logic [31:0] prev_addr;
  logic        prev_rst;
  logic        have_prev = 1'b0;
  logic [2:0]  irq_p1 = 3'b000, irq_p2 = 3'b000;
  logic        rst_p1 = 1'b0, rst_p2 = 1'b0;

  task automatic push(input int k, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [31:0] a,
                      input logic [3:0] be, input logic [2:0] irq,
                      input logic [31:0] dm, input logic [31:0] im,
                      input logic [31:0] t0, input logic [31:0] t1);
    int          r, pr;
    logic [31:0] rd;
    logic [2:0]  hw;
    @(posedge clk);
    #1;
    reset = rst;
    Addr_Bridge = a;
    cpu_m_data_byteen = be;
    {Interrupt, IRQ1, IRQ0} = irq;
    DM_Read = dm;
    IM_Read = im;
    TC0_Read = t0;
    TC1_Read = t1;
    r = region_of(a);
    push(0, {31'd0, (be != 4'd0) && (r == 3)});
    push(1, {31'd0, (be != 4'd0) && (r == 4)});
    push(2, {28'd0, (r == 1 || r == 5) ? be : 4'b0000});
    if (have_prev) begin
      pr = prev_rst ? region_of(prev_addr) : 0;
      case (pr)
        1: rd = dm;
        2: rd = im;
        3: rd = t0;
        4: rd = t1;
        default: rd = 32'h0;
      endcase
      push(3, rd);
    end
`ifdef BRIDGE_HWINT_SYNC_EN
    hw = (rst_p1 && rst_p2) ? irq_p2 : 3'b000;
`else
    hw = irq;
`endif
    push(4, {26'd0, 3'b000, hw});
    prev_addr = a;
    prev_rst  = rst;
    have_prev = 1'b1;
    irq_p2 = irq_p1;
    irq_p1 = irq;
    rst_p2 = rst_p1;
    rst_p1 = rst;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               nm, cyc_cnt, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc != cyc_cnt) begin
        check("stale_entry", 32'(e.cyc), 32'(cyc_cnt));
      end else begin
        case (e.kind)
          0: check("tc0_strobe", {31'd0, TC0_RegWrite}, e.val);
          1: check("tc1_strobe", {31'd0, TC1_RegWrite}, e.val);
          2: check("byteen", {28'd0, bridge_m_data_byteen}, e.val);
          3: check("read", Bridge_Read, e.val);
          default: check("hwint", {26'd0, HWInt}, e.val);
        endcase
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 32'($urandom_range(0, 32'h2FFF));
      1: return 32'($urandom_range(32'h3000, 32'h6FFF));
      2: return 32'($urandom_range(32'h7F00, 32'h7F0B));
      3: return 32'($urandom_range(32'h7F0C, 32'h7F0F));
      4: return 32'($urandom_range(32'h7F10, 32'h7F1B));
      5: return 32'($urandom_range(32'h7F1C, 32'h7F1F));
      6: return 32'($urandom_range(32'h7F20, 32'h7F23));
      7: return 32'($urandom_range(32'h7F24, 32'h7FFF));
      8: return 32'($urandom_range(32'h7000, 32'h7EFF));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r0, r1, r2;
    reset = 1'b0;
    Addr_Bridge = 32'h0;
    cpu_m_data_byteen = 4'h0;
    {Interrupt, IRQ1, IRQ0} = 3'b000;
    DM_Read = 32'h0;
    IM_Read = 32'h0;
    TC0_Read = 32'h0;
    TC1_Read = 32'h0;
    r0 = $urandom; r1 = $urandom; r2 = $urandom;

    step(0, 32'h0, 4'h0, 3'b000, 32'hDEAD_BEEF, r0, r1, r2);
    step(0, 32'h0, 4'h0, 3'b000, 32'hDEAD_BEEF, r0, r1, r2);
    step(1, 32'h0, 4'h0, 3'b000, 32'hDEAD_BEEF, r0, r1, r2);
    step(1, 32'h7F04, 4'hF, 3'b000, 32'hDEAD_BEEF, r0, r1, r2);
    step(1, 32'h7F1B, 4'h3, 3'b000, r0, r1, 32'h1234, r2);
    step(1, 32'h7F1C, 4'hF, 3'b000, r0, r1, r2, 32'h5678);
    step(1, 32'h2FFC, 4'h8, 3'b000, r0, r1, r2, 32'h5678);
    step(1, 32'h3000, 4'hF, 3'b000, 32'hCAFE_0001, r1, r2, r0);
    step(1, 32'h7F20, 4'hF, 3'b000, r0, 32'h1357_9BDF, r2, r1);
    step(1, 32'h7F0B, 4'h0, 3'b000, r0, r1, r2, r0);
    step(1, 32'h6FFF, 4'h1, 3'b101, r0, r1, 32'hA5A5_0000, r2);
    step(1, 32'h7F10, 4'h0, 3'b101, r0, 32'h0F0F_F0F0, r1, r2);
    step(1, 32'h7F23, 4'h2, 3'b101, r0, r1, r2, 32'h7777_1111);
    step(1, 32'h7F24, 4'hF, 3'b101, r0, r1, r2, r0);
    step(0, 32'h7F08, 4'hF, 3'b101, r0, r1, r2, r0);
    step(0, 32'h3004, 4'h0, 3'b101, r0, r1, r2, r0);
    step(1, 32'h0010, 4'h0, 3'b101, r0, r1, r2, r0);
    step(1, 32'hFFFF_FFFF, 4'hF, 3'b101, r0, r1, r2, r0);
    step(1, 32'h0, 4'h0, 3'b010, r1, r1, r2, r0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), rand_addr(),
           4'($urandom), 3'($urandom),
           $urandom, $urandom, $urandom, $urandom);
    end

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
